wb_arb2_rr: RTL and testbench
=============================

// Module: wb_arb2_rr
// PURPOSE
//  Two-master round-robin Wishbone arbiter with a bus-hang watchdog. Shares one slave port
//  between the LM32 instruction bus (m0) and data bus (m1) ahead of the address decoder.
//  Ownership is held for the whole cycle (cyc). A stalled slave is aborted with m_err.
// PARAMETERS
//  adr_width     32   address width, all ports
//  timeout_cyc   255  cycles with owner stb high and no s_ack before abort (min 2, max 2^16-1)
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          asynchronous reset, active-low
//  mN_adr_i       in   adr_width  master N address (N = 0, 1)
//  mN_dat_i       in   32         master N write data
//  mN_dat_o       out  32         master N read data (s_dat_i fanned out)
//  mN_sel_i       in   4          master N byte selects
//  mN_we_i        in   1          master N write enable
//  mN_cyc_i       in   1          master N cycle request
//  mN_stb_i       in   1          master N strobe
//  mN_ack_o       out  1          master N acknowledge
//  mN_err_o       out  1          master N error (watchdog abort)
//  s_adr_o        out  adr_width  slave address
//  s_dat_o        out  32         slave write data
//  s_dat_i        in   32         slave read data
//  s_sel_o        out  4          slave byte selects
//  s_we_o         out  1          slave write enable
//  s_cyc_o        out  1          slave cycle
//  s_stb_o        out  1          slave strobe
//  s_ack_i        in   1          slave acknowledge
//  gnt_o          out  2          one-hot current owner; 2'b00 when idle
//  tout_o         out  1          one-cycle pulse on each watchdog abort
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, gnt_o=0, last=1 (m0 wins the first tie), wdog=0. All m*_ack/err,
//    s_cyc/s_stb/s_we and tout_o are 0. s_adr/s_dat/s_sel are 0.
//  - FSM states: IDLE, BUSY, ABORT, DRAIN.
//  - IDLE: if exactly one mN_cyc_i is high, that master is granted. If both are high, the master
//    != last is granted. On grant: owner<=N, last<=N, go to BUSY (grant is registered, so 1 cycle
//    latency from cyc to s_cyc_o). No request: remain in IDLE.
//  - BUSY: s_* = owner's signals combinationally. s_cyc_o = owner cyc. s_stb_o = owner stb.
//    mN_ack_o = s_ack_i & (owner==N). The non-owner sees ack=err=0 and is stalled.
//    mN_dat_o = s_dat_i for both.
//  - BUSY exit: when owner cyc drops, go to IDLE. At least one idle cycle between grants.
//    Burst and back-to-back strobes under one cyc keep the grant.
//  - Watchdog: wdog clears on entry to BUSY and on every s_ack_i. It increments each BUSY cycle with
//    owner stb=1 & s_ack_i=0. It holds when stb=0.
//  - Timeout: when wdog==timeout_cyc-1 and no ack, go to ABORT.
//  - ABORT (1 cycle): s_cyc_o=s_stb_o=0, owner err=1, tout_o=1. Then go to DRAIN.
//  - DRAIN: s_cyc_o=0. Wait for owner cyc=0, then go to IDLE. Any s_ack_i arriving late is
//    dropped, not forwarded.
//  - s_ack_i in the same cycle the watchdog expires: the ack wins, wdog clears, no abort.
//  - Owner drops cyc in the same cycle as ack: the transfer completes, then IDLE.
//  - wdog width is 16 bits, saturating; no wrap.
//  - Reset mid-cycle: immediate return to reset values. Masters see no ack or err.
// TESTING
//  - m0 alone reads 0x00000010, slave acks after 3 cycles -> gnt_o=01, m0_ack 1 cycle, m1_ack=0.
//  - m0 and m1 raise cyc together from reset -> m0 granted first. After m0 cyc drops, 1 idle cycle,
//    then gnt_o=10.
//  - Both masters request continuously with single-beat cycles -> grants alternate 01,10,01,10.
//  - m1 holds cyc for 4 strobes to 0x20000000 -> gnt stays 10 throughout. m0 waits, then is granted.
//  - timeout_cyc=8, slave never acks m1 -> m1_err and tout_o pulse on cycle 9 after grant,
//    s_cyc_o=0. Next grant proceeds normally.
//  - s_ack_i coincident with expiry -> ack delivered, no err.
//  - rst low while BUSY -> gnt_o=0 and s_cyc_o=0 immediately.

Source files
------------

// File: rtl/wb_arb2_rr_if.sv
// Wishbone classic bus bundle shared by the arbiter's master-facing and slave-facing ports.
// The master modport drives the request side; the slave modport answers it.
interface wb_arb2_rr_if #(
  parameter int unsigned adr_width = 32
) ();
  logic [adr_width-1:0] adr;
  logic [31:0]          wdat;
  logic [31:0]          rdat;
  logic [3:0]           sel;
  logic                 we;
  logic                 cyc;
  logic                 stb;
  logic                 ack;
  logic                 err;

  modport master (
    output adr, wdat, sel, we, cyc, stb,
    input  rdat, ack, err
  );

  modport slave (
    input  adr, wdat, sel, we, cyc, stb,
    output rdat, ack, err
  );
endinterface

// File: rtl/wb_arb2_rr.sv
// Two-master round-robin Wishbone arbiter; ownership spans a whole cyc, and a watchdog
// aborts transfers that the slave never acknowledges.
module wb_arb2_rr #(
  parameter int unsigned adr_width   = 32,
  parameter int unsigned timeout_cyc = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_arb2_rr_if.slave         m0,
  wb_arb2_rr_if.slave         m1,
  wb_arb2_rr_if.master        s,
  output logic [1:0]          gnt_o,
  output logic                tout_o
);

  localparam logic [15:0] TimeoutLast = 16'(timeout_cyc - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDrain} state_e;

  state_e      state_q;
  logic [1:0]  gnt_q;
  logic        last_q;
  logic [15:0] wdog_q;
  logic        tout_q;

  logic                 owner;
  logic                 busy;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 own_we;
  logic [adr_width-1:0] own_adr;
  logic [31:0]          own_wdat;
  logic [3:0]           own_sel;

  assign owner = gnt_q[1];
  assign busy  = (state_q == StBusy);

  always_comb begin
    own_cyc  = m0.cyc;
    own_stb  = m0.stb;
    own_we   = m0.we;
    own_adr  = m0.adr;
    own_wdat = m0.wdat;
    own_sel  = m0.sel;
    if (owner) begin
      own_cyc  = m1.cyc;
      own_stb  = m1.stb;
      own_we   = m1.we;
      own_adr  = m1.adr;
      own_wdat = m1.wdat;
      own_sel  = m1.sel;
    end
  end

  // The slave only sees the owner while BUSY, so reset, ABORT and DRAIN all float it to zero.
  assign s.cyc  = busy & own_cyc;
  assign s.stb  = busy & own_stb;
  assign s.we   = busy & own_we;
  assign s.adr  = busy ? own_adr  : '0;
  assign s.wdat = busy ? own_wdat : '0;
  assign s.sel  = busy ? own_sel  : '0;

  assign m0.ack  = busy & ~owner & s.ack;
  assign m1.ack  = busy &  owner & s.ack;
  assign m0.err  = tout_q & ~owner;
  assign m1.err  = tout_q &  owner;
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;

  assign gnt_o  = gnt_q;
  assign tout_o = tout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // On a tie the master that did not own the bus last time wins.
          if (m0.cyc && (!m1.cyc || last_q)) begin
            gnt_q   <= 2'b01;
            last_q  <= 1'b0;
            wdog_q  <= '0;
            state_q <= StBusy;
          end else if (m1.cyc) begin
            gnt_q   <= 2'b10;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!own_cyc) begin
            gnt_q   <= 2'b00;
            state_q <= StIdle;
          end else if (s.ack) begin
            wdog_q <= '0;
          end else if (own_stb && (wdog_q == TimeoutLast)) begin
            tout_q  <= 1'b1;
            state_q <= StAbort;
          end else if (own_stb && (wdog_q != 16'hFFFF)) begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        StAbort: begin
          state_q <= StDrain;
        end
        StDrain: begin
          if (!own_cyc) begin
            gnt_q   <= 2'b00;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt_q   <= 2'b00;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Bench for wb_arb2_rr: directed scenarios followed by random traffic, all checked each cycle
// against a transaction-level reference of the arbitration rules.
module tb_wb_arb2_rr;

  localparam int Tout = 8;

  logic clk = 1'b0;
  logic rst;

  logic        mc[2];
  logic        ms[2];
  logic        mw[2];
  logic [31:0] ma[2];
  logic [31:0] md[2];
  logic [3:0]  msel[2];
  logic        s_ack;
  logic [31:0] s_rd;
  logic [1:0]  gnt;
  logic        tout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: who owns the bus, how long the current strobe has waited, abort/drain flags.
  int mdl_own;
  int mdl_last;
  int mdl_wait;
  bit mdl_abort;
  bit mdl_drain;

  wb_arb2_rr_if #(.adr_width(32)) m0_bus ();
  wb_arb2_rr_if #(.adr_width(32)) m1_bus ();
  wb_arb2_rr_if #(.adr_width(32)) s_bus ();

  assign m0_bus.cyc  = mc[0];
  assign m0_bus.stb  = ms[0];
  assign m0_bus.we   = mw[0];
  assign m0_bus.adr  = ma[0];
  assign m0_bus.wdat = md[0];
  assign m0_bus.sel  = msel[0];
  assign m1_bus.cyc  = mc[1];
  assign m1_bus.stb  = ms[1];
  assign m1_bus.we   = mw[1];
  assign m1_bus.adr  = ma[1];
  assign m1_bus.wdat = md[1];
  assign m1_bus.sel  = msel[1];
  assign s_bus.ack   = s_ack;
  assign s_bus.rdat  = s_rd;
  assign s_bus.err   = 1'b0;

  wb_arb2_rr #(
    .adr_width  (32),
    .timeout_cyc(Tout)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt_o (gnt),
    .tout_o(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mdl_own   = -1;
    mdl_last  = 1;
    mdl_wait  = 0;
    mdl_abort = 1'b0;
    mdl_drain = 1'b0;
  endfunction

  function automatic void model_update();
    if (mdl_own < 0) begin
      if (mc[0] && mc[1]) mdl_own = 1 - mdl_last;
      else if (mc[0])     mdl_own = 0;
      else if (mc[1])     mdl_own = 1;
      if (mdl_own >= 0) begin
        mdl_last = mdl_own;
        mdl_wait = 0;
      end
    end else if (mdl_abort) begin
      mdl_abort = 1'b0;
      mdl_drain = 1'b1;
    end else if (mdl_drain) begin
      if (!mc[mdl_own]) begin
        mdl_own   = -1;
        mdl_drain = 1'b0;
      end
    end else if (!mc[mdl_own]) begin
      mdl_own = -1;
    end else if (s_ack) begin
      mdl_wait = 0;
    end else if (ms[mdl_own]) begin
      if (mdl_wait == Tout - 1) mdl_abort = 1'b1;
      else if (mdl_wait < 65535) mdl_wait++;
    end
  endfunction

  task automatic model_check();
    int   oi;
    logic live;
    logic [1:0] eg;
    oi   = (mdl_own < 0) ? 0 : mdl_own;
    live = (mdl_own >= 0) && !mdl_abort && !mdl_drain;
    eg   = (mdl_own < 0) ? 2'b00 : ((mdl_own == 0) ? 2'b01 : 2'b10);
    chk("gnt",    32'(gnt),          32'(eg));
    chk("s_cyc",  32'(s_bus.cyc),    32'(live && mc[oi]));
    chk("s_stb",  32'(s_bus.stb),    32'(live && ms[oi]));
    chk("s_we",   32'(s_bus.we),     32'(live && mw[oi]));
    chk("s_adr",  s_bus.adr,         live ? ma[oi] : 32'h0);
    chk("s_dat",  s_bus.wdat,        live ? md[oi] : 32'h0);
    chk("s_sel",  32'(s_bus.sel),    live ? 32'(msel[oi]) : 32'h0);
    chk("m0_ack", 32'(m0_bus.ack),   32'(live && mdl_own == 0 && s_ack));
    chk("m1_ack", 32'(m1_bus.ack),   32'(live && mdl_own == 1 && s_ack));
    chk("m0_err", 32'(m0_bus.err),   32'(mdl_abort && mdl_own == 0));
    chk("m1_err", 32'(m1_bus.err),   32'(mdl_abort && mdl_own == 1));
    chk("tout",   32'(tout),         32'(mdl_abort));
    chk("m0_dat", m0_bus.rdat,       s_rd);
    chk("m1_dat", m1_bus.rdat,       s_rd);
  endtask

  // One clock: check at the falling edge, advance the reference at the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_update();
    #1;
  endtask

  task automatic drive(input int n, input logic c, input logic st, input logic w,
                       input logic [31:0] a);
    mc[n] = c;
    ms[n] = st;
    mw[n] = w;
    ma[n] = a;
    md[n] = a ^ 32'hA5A5_0000;
    msel[n] = 4'hF;
  endtask

  initial begin
    logic [1:0] alt_seq[4];
    alt_seq[0] = 2'b01;
    alt_seq[1] = 2'b10;
    alt_seq[2] = 2'b01;
    alt_seq[3] = 2'b10;

    rst = 1'b1;
    for (int n = 0; n < 2; n++) drive(n, 1'b0, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b0;
    s_rd  = 32'hDEAD_BEEF;
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_scyc", 32'(s_bus.cyc), 32'h0);
    chk("rst_sadr", s_bus.adr, 32'h0);
    chk("rst_tout", 32'(tout), 32'h0);
    step();

    // m0 alone reads 0x10, slave acks on the third BUSY cycle.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
    step();
    #2 chk("a_gnt", 32'(gnt), 32'h1);
    chk("a_adr", s_bus.adr, 32'h10);
    step();
    step();
    s_ack = 1'b1;
    s_rd  = 32'h1234_5678;
    #2 chk("a_m0ack", 32'(m0_bus.ack), 32'h1);
    chk("a_m1ack", 32'(m1_bus.ack), 32'h0);
    chk("a_rdat", m0_bus.rdat, 32'h1234_5678);
    step();
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 chk("a_ack_once", 32'(m0_bus.ack), 32'h0);
    step();
    step();

    // m1 granted, then reset pulled mid-cycle.
    drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step();
    s_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("r_gnt", 32'(gnt), 32'h0);
    chk("r_scyc", 32'(s_bus.cyc), 32'h0);
    chk("r_m1ack", 32'(m1_bus.ack), 32'h0);
    model_reset();
    step();
    s_ack = 1'b0;
    rst   = 1'b1;

    // Both request together out of reset: m0 first, one idle cycle, then m1 bursts 4 beats.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    step();
    s_ack = 1'b1;
    #2 chk("b_gnt0", 32'(gnt), 32'h1);
    step();
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    #2 chk("b_idle", 32'(gnt), 32'h0);
    step();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
    for (int b = 0; b < 4; b++) begin
      ma[1] = 32'h2000_0000 + 32'(b * 4);
      s_ack = 1'b1;
      #2 chk("c_gnt1", 32'(gnt), 32'h2);
      chk("c_m0ack", 32'(m0_bus.ack), 32'h0);
      step();
    end
    s_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    #2 chk("c_idle", 32'(gnt), 32'h0);
    step();
    #2 chk("c_m0gnt", 32'(gnt), 32'h1);

    // Continuous requests from both with single beats alternate the grant.
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0300);
    for (int k = 0; k < 4; k++) begin
      s_ack = 1'b1;
      #2 chk("d_alt", 32'(gnt), 32'(alt_seq[k]));
      step();
      s_ack = 1'b0;
      drive(k % 2, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      drive(k % 2, 1'b1, 1'b1, 1'b0, 32'h0000_0300);
      step();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Slave never acks m1: abort on the ninth cycle after the grant, late ack swallowed.
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500);
    step();
    for (int c = 1; c <= 8; c++) begin
      #2 chk("e_wait_err", 32'(m1_bus.err), 32'h0);
      step();
    end
    #2 chk("e_m1err", 32'(m1_bus.err), 32'h1);
    chk("e_tout", 32'(tout), 32'h1);
    chk("e_scyc", 32'(s_bus.cyc), 32'h0);
    chk("e_m0err", 32'(m0_bus.err), 32'h0);
    step();
    s_ack = 1'b1;
    #2 chk("e_late_ack", 32'(m1_bus.ack), 32'h0);
    chk("e_tout_pulse", 32'(tout), 32'h0);
    step();
    s_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0000_0600);
    step();
    s_ack = 1'b1;
    #2 chk("e_next_gnt", 32'(gnt), 32'h1);
    chk("e_next_ack", 32'(m0_bus.ack), 32'h1);
    step();
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Ack arrives exactly when the watchdog would expire: ack wins.
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0700);
    step();
    for (int c = 1; c <= 7; c++) step();
    s_ack = 1'b1;
    #2 chk("f_ack", 32'(m1_bus.ack), 32'h1);
    chk("f_err", 32'(m1_bus.err), 32'h0);
    step();
    s_ack = 1'b0;
    #2 chk("f_tout", 32'(tout), 32'h0);
    chk("f_still_busy", 32'(s_bus.cyc), 32'h1);
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    step();

    // Random traffic, occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (mc[n]) mc[n] = ($urandom_range(99) < 85);
        else       mc[n] = ($urandom_range(99) < 30);
        ms[n]   = mc[n] & ($urandom_range(99) < 70);
        mw[n]   = 1'($urandom_range(1));
        ma[n]   = $urandom;
        md[n]   = $urandom;
        msel[n] = 4'($urandom);
      end
      s_ack = ($urandom_range(99) < 25);
      s_rd  = $urandom;
      if ($urandom_range(499) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
      end
      step();
      if (!rst) rst = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
